pattern_fetcher: RTL and testbench
==================================

// Module: pattern_fetcher
// PURPOSE
//   Responder side of the channel pattern handshake. On each single-cycle
//   enable strobe from a channel controller it reads the next pattern entry
//   from an external synchronous ROM and decodes it. Loop and end control
//   words are handled internally. It returns pitch index, duration and rest
//   flag with a single-cycle valid strobe. One instance sits per channel,
//   between the channel controller and that channel's pattern ROM.
// PARAMETERS
//   ADDR_WIDTH   8  pattern ROM address width; must be 1..14
//   ROM_LATENCY  1  cycles from o_rom_en high to i_rom_data valid; must be >= 1
// PORTS
//   i_clk       in   1           clock
//   i_rst       in   1           reset, synchronous, active-high
//   i_restart   in   1           pulse: rewind to address 0, clear done/overrun
//   i_enable    in   1           fetch-request strobe from channel controller
//   o_valid     out  1           one-cycle strobe: o_pitch/o_duration/o_rest valid
//   o_pitch     out  6           pitch index for the pitch lookup
//   o_duration  out  8           note length in ticks
//   o_rest      out  1           entry is a rest or end (silence)
//   o_done      out  1           sticky: END word reached
//   o_overrun   out  1           sticky: i_enable seen while not IDLE
//   o_rom_en    out  1           ROM read enable
//   o_rom_addr  out  ADDR_WIDTH  ROM address
//   i_rom_data  in   16          ROM read data
// BEHAVIOUR
//   Reset: state IDLE, addr 0. All outputs 0; o_rom_addr 0.
//   Entry [15:14]: 00 NOTE pitch=[13:8] dur=[7:0]; 01 REST dur=[7:0];
//     10 LOOP target=[ADDR_WIDTH-1:0]; 11 END.
//   FSM: IDLE, READ, WAIT, DECODE.
//     IDLE: i_enable -> READ. Clear jump flag.
//     READ: one cycle. o_rom_en=1, o_rom_addr=addr. -> WAIT.
//     WAIT: ROM_LATENCY-1 cycles, counted down. If ROM_LATENCY=1, WAIT is
//       0 cycles and READ goes straight to DECODE.
//     DECODE: i_rom_data is valid this cycle.
//       NOTE/REST: register fields. addr <= addr+1 (wraps at max to 0).
//         o_valid=1 next cycle. -> IDLE.
//       LOOP, jump flag clear: addr <= target, set jump flag. -> READ.
//       LOOP, jump flag set: treat as END. Prevents infinite loops.
//       END: o_rest=1, o_duration=0, o_pitch=0, o_done<=1. Addr holds.
//         o_valid=1 next cycle. Later enables return END again.
//   Latency with ROM_LATENCY=L: i_enable in cycle n -> o_valid in n+2+L.
//     A taken LOOP adds 1+L cycles.
//   o_pitch/o_duration/o_rest are registered. They hold until the next
//     o_valid and are 0 for REST pitch.
//   i_enable in IDLE during the o_valid cycle is accepted.
//   i_enable while not IDLE: ignored, o_overrun<=1.
//   i_restart at any cycle: addr<=0, done/overrun cleared, FSM -> IDLE.
//     No o_valid for an aborted fetch.
//   i_restart and i_enable in the same cycle: restart wins, enable dropped.
//   i_rst overrides i_restart.
// STRUCTURE
//   Include pattern_defs.vh holds the opcode localparams (OP_NOTE, OP_REST,
//   OP_LOOP, OP_END), the field bit positions and the pitch/duration widths.
//   Shared with the ROM generator and the channel controller.
//   No sub-module; the ROM is external. One FSM block, one registered output
//   block, one address/latency counter block.
// TESTING
//   1. ROM[0]=0x0A10 (NOTE p=10 d=16), L=1. Enable at cycle 5 -> o_valid
//      at 8, pitch 10, dur 16, rest 0; next read at addr 1.
//   2. ROM[1]=0x4020 (REST d=32) -> o_valid, rest 1, dur 32, pitch 0.
//   3. ROM[2]=0x8000 (LOOP->0) -> o_rom_en at addr 2 then addr 0. Returns
//      ROM[0] fields 2 cycles later than case 1; next addr 1.
//   4. ROM[0]=0x8000 (LOOP->0, self-loop) -> second LOOP treated as END.
//      o_done=1, rest 1; repeated enables return END.
//   5. Enable again in a READ cycle -> o_overrun=1, one o_valid only.
//      Restart in a WAIT cycle (L=3) -> no o_valid, addr 0, flags cleared.
//   6. Addr 255 (ADDR_WIDTH=8) holds a NOTE -> o_valid, next read at addr 0.
//      Restart and enable in the same cycle -> no fetch starts.

Source files
------------

// File: rtl/pattern_fetcher_pkg.sv
// Shared pattern-entry encoding: opcodes, field layout and the fetcher FSM states.
// Imported by the fetcher, the ROM generator and the channel controller.
package pattern_fetcher_pkg;

  localparam int ENTRY_W = 16;
  localparam int PITCH_W = 6;
  localparam int DUR_W   = 8;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 14;
  localparam int PITCH_MSB = 13;
  localparam int PITCH_LSB = 8;
  localparam int DUR_MSB   = 7;
  localparam int DUR_LSB   = 0;

  typedef enum logic [1:0] {
    OP_NOTE = 2'b00,
    OP_REST = 2'b01,
    OP_LOOP = 2'b10,
    OP_END  = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e              op;
    logic [PITCH_W-1:0]   pitch;
    logic [DUR_W-1:0]     dur;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DECODE
  } fetch_state_e;

endpackage

// File: rtl/pattern_fetcher.sv
// Per-channel pattern fetcher: on each enable strobe reads the next ROM entry,
// follows one LOOP per fetch, and returns pitch/duration/rest with a valid strobe.
module pattern_fetcher
  import pattern_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_restart,
  input  logic                  i_enable,
  output logic                  o_valid,
  output logic [PITCH_W-1:0]    o_pitch,
  output logic [DUR_W-1:0]      o_duration,
  output logic                  o_rest,
  output logic                  o_done,
  output logic                  o_overrun,
  output logic                  o_rom_en,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [ENTRY_W-1:0]    i_rom_data
);

  localparam int CNT_W = (ROM_LATENCY > 2) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((ROM_LATENCY >= 2) ? ROM_LATENCY - 2 : 0);

  fetch_state_e          state_q;
  logic                  jump_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

  logic                  valid_q, rest_q, done_q, overrun_q, rom_en_q;
  logic [PITCH_W-1:0]    pitch_q;
  logic [DUR_W-1:0]      dur_q;

  entry_t                entry;
  logic [ADDR_WIDTH-1:0] loop_target;
  logic                  accept, stray_enable, decode_now;
  logic                  is_data, take_loop, is_end;

  assign entry       = i_rom_data;
  assign loop_target = i_rom_data[ADDR_WIDTH-1:0];

  // Restart suppresses every event in its cycle, including a coincident enable.
  // NOTE: combinational blocks assign every output up front so no path can infer a latch.
  always_comb begin
    accept       = 1'b0;
    stray_enable = 1'b0;
    decode_now   = 1'b0;
    if (!i_restart) begin
      accept       = i_enable && (state_q == ST_IDLE);
      stray_enable = i_enable && (state_q != ST_IDLE);
      decode_now   = (state_q == ST_DECODE);
    end
    is_data   = decode_now && ((entry.op == OP_NOTE) || (entry.op == OP_REST));
    take_loop = decode_now && (entry.op == OP_LOOP) && !jump_q;
    is_end    = decode_now && ((entry.op == OP_END) || ((entry.op == OP_LOOP) && jump_q));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      jump_q  <= 1'b0;
    end else if (i_restart) begin
      state_q <= ST_IDLE;
      jump_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          jump_q <= 1'b0;
          if (i_enable) state_q <= ST_READ;
        end
        ST_READ: begin
          if (ROM_LATENCY == 1) state_q <= ST_DECODE;
          else                  state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          // A second LOOP within one fetch is decoded as END, so only one jump is taken.
          if (take_loop) begin
            state_q <= ST_READ;
            jump_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (i_restart)      addr_d = '0;
    else if (is_data)   addr_d = addr_q + ADDR_WIDTH'(1);
    else if (take_loop) addr_d = loop_target;

    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_READ)                          wait_cnt_d = WAIT_LOAD;
    else if (state_q == ST_WAIT && wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      addr_q     <= addr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      pitch_q   <= '0;
      dur_q     <= '0;
      rest_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      rom_en_q  <= 1'b0;
    end else begin
      valid_q  <= is_data || is_end;
      rom_en_q <= accept || take_loop;
      if (is_data) begin
        pitch_q <= (entry.op == OP_NOTE) ? entry.pitch : '0;
        dur_q   <= entry.dur;
        rest_q  <= (entry.op == OP_REST);
      end else if (is_end) begin
        pitch_q <= '0;
        dur_q   <= '0;
        rest_q  <= 1'b1;
      end
      if (i_restart) begin
        done_q    <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        if (is_end)       done_q    <= 1'b1;
        if (stray_enable) overrun_q <= 1'b1;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_pitch    = pitch_q;
  assign o_duration = dur_q;
  assign o_rest     = rest_q;
  assign o_done     = done_q;
  assign o_overrun  = overrun_q;
  assign o_rom_en   = rom_en_q;
  assign o_rom_addr = addr_q;

endmodule

// File: tb/tb_pattern_fetcher.sv
// Directed bench for pattern_fetcher: one instance with ROM latency 1, one with 3,
// each fed by a behavioural synchronous ROM.
module tb_pattern_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // ROM latency 1 instance
  logic        en1, rs1, v1, r1, dn1, ov1, re1;
  logic [5:0]  p1;
  logic [7:0]  d1, ra1;
  logic [15:0] rd1;
  logic [15:0] rom1 [256];

  // ROM latency 3 instance
  logic        en3, rs3, v3, r3, dn3, ov3, re3;
  logic [5:0]  p3;
  logic [7:0]  d3, ra3;
  logic [15:0] rd3, pipe0, pipe1;
  logic [15:0] rom3 [256];

  int passed = 0;
  int total  = 0;

  pattern_fetcher #(.ADDR_WIDTH(8), .ROM_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_restart(rs1), .i_enable(en1),
    .o_valid(v1), .o_pitch(p1), .o_duration(d1), .o_rest(r1),
    .o_done(dn1), .o_overrun(ov1), .o_rom_en(re1), .o_rom_addr(ra1),
    .i_rom_data(rd1)
  );

  pattern_fetcher #(.ADDR_WIDTH(8), .ROM_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_restart(rs3), .i_enable(en3),
    .o_valid(v3), .o_pitch(p3), .o_duration(d3), .o_rest(r3),
    .o_done(dn3), .o_overrun(ov3), .o_rom_en(re3), .o_rom_addr(ra3),
    .i_rom_data(rd3)
  );

  // Unread cycles return a recognisable NOTE (p=63, d=63) instead of holding data.
  always @(posedge clk) rd1 <= re1 ? rom1[ra1] : 16'h3F3F;

  always @(posedge clk) begin
    pipe0 <= re3 ? rom3[ra3] : 16'h3F3F;
    pipe1 <= pipe0;
    rd3   <= pipe1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse1();
    en1 = 1'b1; tick(); en1 = 1'b0;
  endtask

  task automatic pulse3();
    en3 = 1'b1; tick(); en3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom1[i] = 16'hC000;
      rom3[i] = 16'hC000;
    end
    rom1[0]   = 16'h0A10;
    rom1[1]   = 16'h4020;
    rom1[2]   = 16'h8000;
    rom1[255] = 16'h3F05;
    rom3[0]   = 16'h0A10;
    rom3[1]   = 16'h4020;

    rst = 1'b1; en1 = 1'b0; rs1 = 1'b0; en3 = 1'b0; rs3 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid",    v1,  0);
    check("rst_pitch",    p1,  0);
    check("rst_dur",      d1,  0);
    check("rst_rest",     r1,  0);
    check("rst_done",     dn1, 0);
    check("rst_overrun",  ov1, 0);
    check("rst_rom_en",   re1, 0);
    check("rst_rom_addr", ra1, 0);

    // NOTE at addr 0, latency 1: valid on the third cycle after the enable cycle
    pulse1();
    check("t1_read_en",   re1, 1);
    check("t1_read_addr", ra1, 0);
    check("t1_read_v",    v1,  0);
    tick();
    check("t1_dec_en",    re1, 0);
    check("t1_dec_v",     v1,  0);
    tick();
    check("t1_valid",     v1,  1);
    check("t1_pitch",     p1,  10);
    check("t1_dur",       d1,  16);
    check("t1_rest",      r1,  0);
    check("t1_next_addr", ra1, 1);
    tick();
    check("t1_v_drop",    v1,  0);
    check("t1_hold_p",    p1,  10);

    // REST at addr 1
    pulse1();
    check("t2_read_addr", ra1, 1);
    tick(); tick();
    check("t2_valid",     v1,  1);
    check("t2_rest",      r1,  1);
    check("t2_dur",       d1,  32);
    check("t2_pitch",     p1,  0);

    // LOOP at addr 2 back to 0 adds two cycles
    pulse1();
    check("t3_read_addr", ra1, 2);
    check("t3_read_en",   re1, 1);
    tick();
    check("t3_dec_v",     v1,  0);
    tick();
    check("t3_reread_en", re1, 1);
    check("t3_reread_a",  ra1, 0);
    check("t3_reread_v",  v1,  0);
    tick();
    check("t3_dec2_v",    v1,  0);
    tick();
    check("t3_valid",     v1,  1);
    check("t3_pitch",     p1,  10);
    check("t3_dur",       d1,  16);
    check("t3_next_addr", ra1, 1);
    check("t3_done",      dn1, 0);

    // Enable during the o_valid cycle is accepted
    pulse1();
    check("bb_read_en",   re1, 1);
    check("bb_read_addr", ra1, 1);
    check("bb_overrun",   ov1, 0);
    tick(); tick();
    check("bb_valid",     v1,  1);
    check("bb_rest",      r1,  1);

    // Enable during READ sets overrun; the fetch still yields one valid
    pulse1();
    check("t5_read_addr", ra1, 2);
    en1 = 1'b1; tick(); en1 = 1'b0;
    check("t5_overrun",   ov1, 1);
    check("t5_dec_v",     v1,  0);
    tick();
    check("t5_reread_a",  ra1, 0);
    tick();
    check("t5_dec2_v",    v1,  0);
    tick();
    check("t5_valid",     v1,  1);
    check("t5_pitch",     p1,  10);
    tick();
    check("t5_one_valid", v1,  0);
    check("t5_ov_sticky", ov1, 1);

    rs1 = 1'b1; tick(); rs1 = 1'b0;
    check("rs_overrun",   ov1, 0);
    check("rs_addr",      ra1, 0);

    // Self-loop at addr 0: the second LOOP is decoded as END
    rom1[0] = 16'h8000;
    pulse1(); tick(); tick(); tick();
    check("t4_pre_v",     v1,  0);
    tick();
    check("t4_valid",     v1,  1);
    check("t4_rest",      r1,  1);
    check("t4_dur",       d1,  0);
    check("t4_pitch",     p1,  0);
    check("t4_done",      dn1, 1);
    check("t4_addr_hold", ra1, 0);
    tick();
    pulse1(); tick(); tick(); tick();
    check("t4b_pre_v",    v1,  0);
    tick();
    check("t4b_valid",    v1,  1);
    check("t4b_rest",     r1,  1);
    check("t4b_done",     dn1, 1);

    // Wrap from addr 255 to 0 after a NOTE
    rom1[0] = 16'h80FF;
    rs1 = 1'b1; tick(); rs1 = 1'b0;
    check("t6_rs_done",   dn1, 0);
    pulse1(); tick();
    tick();
    check("t6_read_255",  ra1, 255);
    check("t6_read_en",   re1, 1);
    tick(); tick();
    check("t6_valid",     v1,  1);
    check("t6_pitch",     p1,  63);
    check("t6_dur",       d1,  5);
    check("t6_wrap_addr", ra1, 0);

    // Restart and enable together: nothing starts
    rs1 = 1'b1; en1 = 1'b1; tick(); rs1 = 1'b0; en1 = 1'b0;
    check("t6b_rom_en",   re1, 0);
    check("t6b_overrun",  ov1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6b_no_valid", v1, 0);
    end

    // Latency 3: valid on the fifth cycle after the enable cycle
    pulse3();
    check("l3_read_en",   re3, 1);
    check("l3_read_addr", ra3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("l3_wait_v",  v3,  0);
    end
    tick();
    check("l3_valid",     v3,  1);
    check("l3_pitch",     p3,  10);
    check("l3_dur",       d3,  16);
    check("l3_next_addr", ra3, 1);

    // Overrun during READ, then restart during WAIT aborts the fetch
    tick();
    pulse3();
    check("l3b_read_a",   ra3, 1);
    en3 = 1'b1; tick(); en3 = 1'b0;
    check("l3b_overrun",  ov3, 1);
    rs3 = 1'b1; tick(); rs3 = 1'b0;
    check("l3b_rs_ov",    ov3, 0);
    check("l3b_rs_addr",  ra3, 0);
    check("l3b_rs_done",  dn3, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("l3b_no_valid", v3, 0);
    end
    pulse3();
    check("l3c_read_a",   ra3, 0);
    tick(); tick(); tick(); tick();
    check("l3c_valid",    v3,  1);
    check("l3c_pitch",    p3,  10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
